// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream packetizer.
//   DATA_W  : default stream data width (bits), multiple of 8
//   KEEP_W  : byte-enable width
//   state_t : framing FSM states
//   beat_t  : one stream beat as carried through the skid buffer
package axis_pkg;

    localparam int DATA_W = 16;
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CLOSE
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

endpackage

// File: rtl/axis_packetizer_if.sv
// AXI-Stream bundle used on both sides of the packetizer.
//   master : drives tdata/tkeep/tvalid/tlast, receives tready
//   slave  : receives tdata/tkeep/tvalid, drives tready (input side is unframed, tlast unused)
interface axis_packetizer_if
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
) ();

    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, output tready);

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry register slice: an output register plus one skid entry.
// The input ready is a flop (not full), so there is no combinational path
// from out_ready back to in_ready; full throughput with 1-cycle latency.
//   clk, rst_n          : clock, async active-low reset
//   in_beat/in_valid    : beat offered by the framing logic
//   in_ready            : registered "skid entry free"
//   out_beat/out_valid  : registered output beat
//   out_ready           : downstream ready
module axis_skid_buf
    import axis_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  beat_t in_beat,
    input  logic  in_valid,
    output logic  in_ready,
    output beat_t out_beat,
    output logic  out_valid,
    input  logic  out_ready
);

    beat_t skid_q;
    logic  skid_vld;
    logic  acc;
    logic  out_free;

    assign acc      = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_beat  <= '0;
            out_valid <= 1'b0;
            skid_q    <= '0;
            skid_vld  <= 1'b0;
            in_ready  <= 1'b0;
        end else if (out_free) begin
            // in_ready == !skid_vld, so a held skid beat and a new accept never coexist
            if (skid_vld) begin
                out_beat  <= skid_q;
                out_valid <= 1'b1;
                skid_vld  <= 1'b0;
            end else begin
                out_valid <= acc;
                if (acc) out_beat <= in_beat;
            end
            in_ready <= 1'b1;
        end else if (acc) begin
            // output stalled: park the new beat and close the input
            skid_q   <= in_beat;
            skid_vld <= 1'b1;
            in_ready <= 1'b0;
        end else begin
            in_ready <= !skid_vld;
        end
    end

endmodule

// File: rtl/axis_packetizer.sv
// Converts an unframed AXI-Stream into fixed-length frames by generating
// tlast; pulses frame_done and counts frames on each tlast handshake.
//   clk, rst_n     : clock, async active-low reset
//   cfg_frame_len  : beats per frame, sampled on a frame's first beat (0 -> 1)
//   flush          : closes the open frame early (ignored in IDLE)
//   s              : unframed input stream (slave)
//   m              : framed output stream (master), via 2-entry skid buffer
//   frame_done     : registered pulse one cycle after a tlast handshake
//   frame_cnt      : completed frames, wrapping
// Optional: define AXIS_PACKETIZER_TIMEOUT_EN to close a frame left idle for
// TIMEOUT_CYC cycles by injecting a null beat (tdata=0, tkeep=0, tlast=1).
module axis_packetizer
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int LEN_W      = 14,
    parameter int CNT_W      = 16
`ifdef AXIS_PACKETIZER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 256
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LEN_W-1:0]      cfg_frame_len,
    input  logic                  flush,
    axis_packetizer_if.slave      s,
    axis_packetizer_if.master     m,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      frame_cnt
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state, state_n;
    logic [LEN_W-1:0] beat_cnt, beat_cnt_n;
    logic [LEN_W-1:0] len_q, len_n, len_in;
    logic             buf_ready;
    logic             accept;
    logic             tag_last;
    logic             inject;
    logic             in_valid;
    beat_t            in_beat, out_beat;
    logic             out_valid;
    logic             out_hs_last;

    assign len_in   = (cfg_frame_len == '0) ? ONE : cfg_frame_len;
    assign s.tready = buf_ready && !inject;
    assign accept   = s.tvalid && s.tready;

`ifdef AXIS_PACKETIZER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);

    logic [TMR_W-1:0] timer;

    // Idle cycles inside an open frame; saturates until the null beat fits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  timer <= '0;
        else if (accept || inject || state == IDLE)  timer <= '0;
        else if (timer != TMR_MAX)                   timer <= timer + TMR_W'(1);
    end

    assign inject = (timer == TMR_MAX) && buf_ready;
`else
    assign inject = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            len_q    <= ONE;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_cnt_n;
            len_q    <= len_n;
        end
    end

    always_comb begin
        state_n    = state;
        beat_cnt_n = beat_cnt;
        len_n      = len_q;
        tag_last   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (len_in == ONE) begin
                        tag_last = 1'b1;
                    end else begin
                        len_n      = len_in;
                        beat_cnt_n = ONE;
                        state_n    = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    // a flush landing on the len-th beat still yields one tlast
                    if (beat_cnt + ONE == len_q || flush) begin
                        tag_last   = 1'b1;
                        beat_cnt_n = '0;
                        state_n    = IDLE;
                    end else begin
                        beat_cnt_n = beat_cnt + ONE;
                    end
                end else if (flush) begin
                    state_n = CLOSE;
                end
            end
            CLOSE: begin
                if (accept) begin
                    tag_last   = 1'b1;
                    beat_cnt_n = '0;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (inject) begin
            state_n    = IDLE;
            beat_cnt_n = '0;
        end
    end

    assign in_valid = accept || inject;
    assign in_beat  = inject ? beat_t'{data: '0, keep: '0, last: 1'b1}
                             : beat_t'{data: s.tdata, keep: s.tkeep, last: tag_last};

    axis_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_beat   (in_beat),
        .in_valid  (in_valid),
        .in_ready  (buf_ready),
        .out_beat  (out_beat),
        .out_valid (out_valid),
        .out_ready (m.tready)
    );

    assign m.tdata  = out_beat.data;
    assign m.tkeep  = out_beat.keep;
    assign m.tlast  = out_beat.last;
    assign m.tvalid = out_valid;

    assign out_hs_last = out_valid && m.tready && out_beat.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= out_hs_last;
            if (out_hs_last) frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_axis_packetizer.sv
module tb_axis_packetizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] cfg_frame_len;
    logic        flush;
    logic        frame_done;
    logic [15:0] frame_cnt;

    axis_packetizer_if #(.DATA_WIDTH(16)) s_if ();
    axis_packetizer_if #(.DATA_WIDTH(16)) m_if ();

    axis_packetizer #(
        .DATA_WIDTH (16),
        .LEN_W      (14),
        .CNT_W      (16)
`ifdef AXIS_PACKETIZER_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(8)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_frame_len (cfg_frame_len),
        .flush         (flush),
        .s             (s_if),
        .m             (m_if),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // output monitor: a handshake is seen at the negedge before its posedge
    logic [15:0] q_data[$];
    logic [1:0]  q_keep[$];
    logic        q_last[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (m_if.tvalid && m_if.tready) begin
            q_data.push_back(m_if.tdata);
            q_keep.push_back(m_if.tkeep);
            q_last.push_back(m_if.tlast);
        end
        if (frame_done) done_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_keep.delete();
        q_last.delete();
    endtask

    // called at posedge+1; leaves tvalid high so back-to-back calls stream
    task automatic send_beat(input logic [15:0] d, input logic fl);
        int n;
        n = 0;
        s_if.tdata  = d;
        s_if.tkeep  = 2'b11;
        s_if.tvalid = 1'b1;
        flush       = fl;
        @(negedge clk);
        while (!s_if.tready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic chk_stream(input string tag, input logic [15:0] base, input int nb,
                              input logic [15:0] mask);
        chk({tag, "_count"}, 32'(q_data.size()), 32'(nb));
        for (int b = 0; b < nb; b++) begin
            if (b < q_data.size()) begin
                chk($sformatf("%s_data%0d", tag, b), 32'(q_data[b]), 32'(base + 16'(b)));
                chk($sformatf("%s_last%0d", tag, b), 32'(q_last[b]), 32'(mask[b]));
            end
        end
    endtask

    typedef struct {
        logic [13:0] len;
        logic [13:0] len2;          // cfg value applied after the first beat
        int          nbeats;
        logic [15:0] base;
        bit          flush_before;  // flush pulse with no beat, before the beats
        bit          flush_on_last; // flush together with the final beat
        logic [15:0] mask;          // expected tlast per beat
        int          frames;
    } vec_t;

    localparam int NV = 10;
    vec_t vec[NV];

    int          exp_cnt;
    int          d0;
    int          acc;
    int          n;

    initial begin
        vec[0] = '{14'd4, 14'd4, 10, 16'h0000, 1'b0, 1'b0, 16'h0088, 2}; // tlast on 3,7; 8,9 open
        vec[1] = '{14'd4, 14'd4,  1, 16'h000A, 1'b1, 1'b0, 16'h0001, 1}; // flush then beat 10
        vec[2] = '{14'd0, 14'd0,  3, 16'h0020, 1'b0, 1'b0, 16'h0007, 3}; // len 0 -> 1
        vec[3] = '{14'd1, 14'd1,  3, 16'h0030, 1'b0, 1'b0, 16'h0007, 3};
        vec[4] = '{14'd3, 14'd3,  6, 16'h0040, 1'b0, 1'b0, 16'h0024, 2};
        vec[5] = '{14'd2, 14'd2,  2, 16'h0050, 1'b1, 1'b0, 16'h0002, 1}; // flush in IDLE ignored
        vec[6] = '{14'd4, 14'd4,  2, 16'h0060, 1'b0, 1'b1, 16'h0002, 1}; // flush with accept
        vec[7] = '{14'd2, 14'd2,  2, 16'h0070, 1'b0, 1'b1, 16'h0002, 1}; // flush on len-th beat
        vec[8] = '{14'd2, 14'd2,  2, 16'h0080, 1'b0, 1'b0, 16'h0002, 1}; // no stray frame after 7
        vec[9] = '{14'd3, 14'd5,  3, 16'h0090, 1'b0, 1'b0, 16'h0004, 1}; // cfg change mid-frame

        rst_n         = 1'b0;
        cfg_frame_len = 14'd4;
        flush         = 1'b0;
        s_if.tdata    = '0;
        s_if.tkeep    = '0;
        s_if.tvalid   = 1'b0;
        s_if.tlast    = 1'b0;
        m_if.tready   = 1'b1;
        exp_cnt       = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_if.tlast), 32'd0);
        chk("rst_m_tdata", 32'(m_if.tdata), 32'd0);
        chk("rst_m_tkeep", 32'(m_if.tkeep), 32'd0);
        chk("rst_s_tready", 32'(s_if.tready), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("s_tready_after_rst", 32'(s_if.tready), 32'd1);

        for (int r = 0; r < NV; r++) begin
            clear_q();
            d0 = done_cnt;
            cfg_frame_len = vec[r].len;
            if (vec[r].flush_before) begin
                flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
            for (int b = 0; b < vec[r].nbeats; b++) begin
                if (b == 1) cfg_frame_len = vec[r].len2;
                send_beat(vec[r].base + 16'(b), vec[r].flush_on_last && (b == vec[r].nbeats - 1));
            end
            s_if.tvalid = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            exp_cnt += vec[r].frames;
            chk_stream($sformatf("v%0d", r), vec[r].base, vec[r].nbeats, vec[r].mask);
            chk($sformatf("v%0d_done", r), 32'(done_cnt - d0), 32'(vec[r].frames));
            chk($sformatf("v%0d_frame_cnt", r), 32'(frame_cnt), 32'(exp_cnt));
        end

        // backpressure: output held 5 cycles while the input streams
        clear_q();
        d0 = done_cnt;
        cfg_frame_len = 14'd4;
        m_if.tready = 1'b0;
        fork
            begin
                for (int b = 0; b < 8; b++) send_beat(16'h00A0 + 16'(b), 1'b0);
                s_if.tvalid = 1'b0;
            end
            begin
                acc = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (s_if.tvalid && s_if.tready) acc++;
                end
                chk("stall_accepts", 32'(acc), 32'd2);
                chk("stall_s_tready", 32'(s_if.tready), 32'd0);
                chk("stall_m_tvalid", 32'(m_if.tvalid), 32'd1);
                chk("stall_m_tdata", 32'(m_if.tdata), 32'h00A0);
                chk("stall_m_tlast", 32'(m_if.tlast), 32'd0);
                @(posedge clk);
                #1 m_if.tready = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        exp_cnt += 2;
        chk_stream("stall", 16'h00A0, 8, 16'h0088);
        chk("stall_done", 32'(done_cnt - d0), 32'd2);
        chk("stall_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // reset with two beats buffered mid-frame
        clear_q();
        m_if.tready = 1'b0;
        send_beat(16'h00B0, 1'b0);
        send_beat(16'h00B1, 1'b0);
        s_if.tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("midrst_s_tready", 32'(s_if.tready), 32'd0);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_if.tready = 1'b1;
        exp_cnt = 0;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        for (int b = 0; b < 4; b++) send_beat(16'h0010 + 16'(b), 1'b0);
        s_if.tvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk_stream("postrst", 16'h0010, 4, 16'h0008);
        chk("postrst_done", 32'(done_cnt - d0), 32'd1);
        chk("postrst_frame_cnt", 32'(frame_cnt), 32'd1);
        exp_cnt = 1;

`ifdef AXIS_PACKETIZER_TIMEOUT_EN
        // idle open frame is closed by a null beat
        clear_q();
        d0 = done_cnt;
        cfg_frame_len = 14'd4;
        send_beat(16'h00C0, 1'b0);
        send_beat(16'h00C1, 1'b0);
        s_if.tvalid = 1'b0;
        n = 0;
        while (q_data.size() < 3 && n < 40) begin
            n++;
            @(posedge clk);
        end
        if (n >= 40) chk("tmo_wait", 32'(n), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("tmo_count", 32'(q_data.size()), 32'd3);
        if (q_data.size() >= 3) begin
            chk("tmo_b0_last", 32'(q_last[0]), 32'd0);
            chk("tmo_b1_last", 32'(q_last[1]), 32'd0);
            chk("tmo_null_data", 32'(q_data[2]), 32'd0);
            chk("tmo_null_keep", 32'(q_keep[2]), 32'd0);
            chk("tmo_null_last", 32'(q_last[2]), 32'd1);
        end
        chk("tmo_done", 32'(done_cnt - d0), 32'd1);
        chk("tmo_frame_cnt", 32'(frame_cnt), 32'(exp_cnt + 1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog so the run always ends with a summary
    initial begin
        #200000;
        bad++;
        total++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
